vga_wb_arbiter: RTL and testbench
=================================

Name: vga_wb_arbiter

Overview:
- Shares the single WISHBONE read-master port of the VGA core between NREQ internal requesters: 0 = video-memory fetch, 1 = CLUT fetch, 2 = hardware-cursor fetch.
- Sits between the fetch/colour-processor logic and the WISHBONE pins.
- Grants whole bursts using fixed priority with starvation override.
- Routes ACK/ERR back to the bus owner and raises SINT on bus errors.

Parameters:
- NREQ, 3: number of requesters, 2..4.
- STARVE_LIM, 8: lost arbitrations after which a pending requester is forced to win; 1..15.

Ports:
- CLK_I  in  1  master clock.
- nRESET  in  1  asynchronous active-low reset.
- RST_I  in  1  synchronous active-high reset.
- ena  in  1  arbiter enable (ctrl_ven); low = synchronous soft clear.
- req_i  in  NREQ  per-requester bus request, held until its last beat is acked.
- last_i  in  NREQ  per-requester "current beat is last of burst".
- adr_i  in  NREQ*30  packed word addresses [31:2]; requester k occupies bits k*30+29..k*30.
- gnt_o  out  NREQ  one-hot current owner.
- ack_o  out  NREQ  ACK_I routed to owner.
- err_o  out  NREQ  ERR_I routed to owner.
- CYC_O  out  1  WISHBONE cycle.
- STB_O  out  1  WISHBONE strobe.
- CAB_O  out  1  consecutive-address burst.
- WE_O  out  1  tied 0 (read only).
- SEL_O  out  4  tied 4'b1111.
- ADR_O  out  30  owner's address.
- ACK_I  in  1  WISHBONE acknowledge.
- ERR_I  in  1  WISHBONE error.
- SINT  out  1  sticky error interrupt.

Behaviour:
- Clock and reset: CLK_I, reset nRESET asynchronous active-low.
- Reset values (nRESET low, RST_I high, or ena low at a clock edge): state IDLE; gnt_o=0; CYC_O=STB_O=CAB_O=0; SINT=0; all starvation counters 0.
- RST_I and ena-low clears are synchronous.
- Abort mid-burst: CYC_O/STB_O drop at the next edge and the beat is not acked to the requester.
- States: IDLE, BUS, RECOVER.
- IDLE:
  - If any req_i is set, select a winner, register gnt_o, assert CYC_O=STB_O=1, go to BUS. Latency is one cycle from req_i to CYC_O.
  - Winner selection: if any pending requester's counter equals STARVE_LIM, the lowest-indexed such requester wins. Otherwise the lowest index wins.
- Starvation counters (4 bits each), updated at every grant:
  - Each pending non-winner's counter increments, saturating at STARVE_LIM.
  - The winner's counter clears.
  - Non-pending requesters' counters clear.
- BUS:
  - CYC_O=STB_O=1.
  - CAB_O = NOT last_i[owner], registered and updated each beat.
  - ADR_O = adr_i[owner] combinationally; ADR_O = 0 when gnt_o is 0.
  - ack_o[owner] = ACK_I and err_o[owner] = ERR_I, combinationally; all others 0.
  - ACK_I with last_i[owner] = 1: go to RECOVER.
  - ACK_I without last_i: stay in BUS; the requester advances its address.
  - req_i[owner] dropping with no ACK_I: go to RECOVER (abandoned burst).
  - ERR_I: set SINT, go to RECOVER.
  - ACK_I and ERR_I in the same cycle: treated as ERR (no ack_o).
- RECOVER: CYC_O=STB_O=CAB_O=0, gnt_o=0 for exactly one cycle, then IDLE.
  - Guarantees a cycle gap between owners.
  - Back-to-back bursts by the same requester each pay 1 RECOVER + 1 IDLE cycle.
- SINT is cleared only by reset, RST_I, or ena low.

Optional Feature:
- Macro: VGA_WB_ARB_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts BUS cycles without ACK_I/ERR_I and clears on ACK_I/ERR_I. Reaching 255 is treated exactly as ERR_I: err_o[owner] pulses, SINT sets, go to RECOVER.
- Not defined: no watchdog; BUS waits indefinitely.

Decomposition:
- Package vga_wb_arb_pkg:
  - state encoding constants IDLE=2'd0, BUS=2'd1, RECOVER=2'd2;
  - counter width constant STARVE_W=4;
  - watchdog limit constant WDOG_MAX=8'd255.
- Sub-module vga_arb_pick: combinational winner select from req and starvation-at-limit vectors, giving a one-hot result.

Test Plan:
- Single burst: req_i=001, last_i on 4th ack, ACK_I every cycle -> CYC_O rises 1 cycle after req, 4 ack_o[0] pulses, CYC_O low in RECOVER, gnt_o=000 for 1 cycle.
- Priority: req_i=111 simultaneously -> gnt_o=001; after that burst with req_i=110, gnt_o=010.
- Starvation (STARVE_LIM=8): req0 continuously re-requests single beats while req2 is held -> req2 granted on the 9th arbitration despite req0 pending.
- Error: ERR_I asserted on 2nd beat of a requester-1 burst -> err_o=010 for 1 cycle, no ack_o, SINT=1, RECOVER; SINT stays 1 until ena=0.
- Abort: ena dropped mid-burst -> CYC_O=0 next edge, SINT=0, counters 0. nRESET asserted asynchronously mid-burst -> all outputs zero immediately.
- Timeout (macro defined): owner granted, ACK_I held 0 -> at 255 cycles err_o pulses, SINT=1. Macro undefined -> CYC_O stays 1 for 1000 cycles.

Source files
------------

// File: rtl/vga_wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_wb_arb_pkg                                                       |
// | Shared types and constants for the VGA WISHBONE read arbiter.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vga_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam int         STARVE_W = 4;
  localparam int         ADR_W    = 30;
  localparam logic [7:0] WDOG_MAX = 8'd255;

endpackage
`default_nettype wire

// File: rtl/vga_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_arb_pick                                                         |
// | One-hot winner select: starved requesters first, then lowest index.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_arb_pick
  import vga_wb_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_at_lim,
  output logic [NREQ-1:0] o_gnt
);

  logic [NREQ-1:0] w_src;

  // Isolating the lowest set bit of the candidate set gives index-0-first priority.
  assign w_src = (|i_at_lim) ? i_at_lim : i_req;
  assign o_gnt = w_src & (~w_src + NREQ'(1));

endmodule
`default_nettype wire

// File: rtl/vga_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_wb_arbiter                                                       |
// | Burst-granting WISHBONE read arbiter with starvation override.       |
// | Optional BUS watchdog enabled by macro VGA_WB_ARB_TIMEOUT_EN.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_wb_arbiter
  import vga_wb_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic                    CLK_I,
  input  logic                    nRESET,
  input  logic                    RST_I,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         last_i,
  input  logic [NREQ*ADR_W-1:0]   adr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         err_o,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    CAB_O,
  output logic                    WE_O,
  output logic [3:0]              SEL_O,
  output logic [ADR_W-1:0]        ADR_O,
  input  logic                    ACK_I,
  input  logic                    ERR_I,
  output logic                    SINT
);

  localparam logic [STARVE_W-1:0] c_starve_lim = STARVE_W'(STARVE_LIM);

  arb_state_t          r_state;
  logic [NREQ-1:0]     r_gnt;
  logic                r_cyc;
  logic                r_cab;
  logic                r_sint;
  logic [STARVE_W-1:0] r_starve [NREQ];

  logic [NREQ-1:0]     w_at_lim;
  logic [NREQ-1:0]     w_win;
  logic [ADR_W-1:0]    w_adr;
  logic                w_live;
  logic                w_tmo;
  logic                w_fault;
  logic                w_own_req;
  logic                w_own_last;

  generate
    for (genvar k = 0; k < NREQ; k++) begin : g_lim
      assign w_at_lim[k] = req_i[k] && (r_starve[k] == c_starve_lim);
    end
  endgenerate

  vga_arb_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req_i),
    .i_at_lim (w_at_lim),
    .o_gnt    (w_win)
  );

  always_comb begin
    w_adr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gnt[k]) w_adr = w_adr | adr_i[k*ADR_W +: ADR_W];
    end
  end

  assign w_live     = ena && !RST_I;
  assign w_fault    = ERR_I || w_tmo;
  assign w_own_req  = |(req_i & r_gnt);
  assign w_own_last = |(last_i & r_gnt);

`ifdef VGA_WB_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;

  always_ff @(posedge CLK_I or negedge nRESET) begin
    if (!nRESET) begin
      r_wdog <= '0;
    end else if (!w_live || r_state != BUS || ACK_I || ERR_I) begin
      r_wdog <= '0;
    end else if (r_wdog != WDOG_MAX) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_tmo = (r_state == BUS) && (r_wdog == WDOG_MAX);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge CLK_I or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_cyc   <= 1'b0;
      r_cab   <= 1'b0;
      r_sint  <= 1'b0;
      for (int k = 0; k < NREQ; k++) r_starve[k] <= '0;
    end else if (!w_live) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_cyc   <= 1'b0;
      r_cab   <= 1'b0;
      r_sint  <= 1'b0;
      for (int k = 0; k < NREQ; k++) r_starve[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_state <= BUS;
            r_gnt   <= w_win;
            r_cyc   <= 1'b1;
            r_cab   <= ~|(last_i & w_win);
            // Losers that are still waiting age; everyone else starts fresh.
            for (int k = 0; k < NREQ; k++) begin
              if (req_i[k] && !w_win[k])
                r_starve[k] <= (r_starve[k] == c_starve_lim) ? c_starve_lim
                                                              : r_starve[k] + STARVE_W'(1);
              else
                r_starve[k] <= '0;
            end
          end
        end
        BUS: begin
          if (w_fault || (ACK_I && w_own_last) || (!ACK_I && !w_own_req)) begin
            r_state <= RECOVER;
            r_gnt   <= '0;
            r_cyc   <= 1'b0;
            r_cab   <= 1'b0;
            if (w_fault) r_sint <= 1'b1;
          end else begin
            r_cab <= ~w_own_last;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_cyc   <= 1'b0;
          r_cab   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o = r_gnt;
  assign ack_o = r_gnt & {NREQ{w_live && ACK_I && !w_fault}};
  assign err_o = r_gnt & {NREQ{w_live && w_fault}};
  assign CYC_O = r_cyc;
  assign STB_O = r_cyc;
  assign CAB_O = r_cab;
  assign WE_O  = 1'b0;
  assign SEL_O = 4'b1111;
  assign ADR_O = w_adr;
  assign SINT  = r_sint;

endmodule
`default_nettype wire

// File: tb/tb_vga_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_wb_arbiter                                                    |
// | Randomized bench for vga_wb_arbiter against a burst-level model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_wb_arbiter;

  localparam int NREQ       = 3;
  localparam int STARVE_LIM = 8;
`ifdef VGA_WB_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int EXP_HOLD = TMO ? 256 : 1000;

  logic                 CLK_I  = 1'b0;
  logic                 nRESET = 1'b0;
  logic                 RST_I  = 1'b0;
  logic                 ena    = 1'b0;
  logic [NREQ-1:0]      req_i  = '0;
  logic [NREQ-1:0]      last_i = '0;
  logic [NREQ*30-1:0]   adr_i  = '0;
  logic [NREQ-1:0]      gnt_o, ack_o, err_o;
  logic                 CYC_O, STB_O, CAB_O, WE_O;
  logic [3:0]           SEL_O;
  logic [29:0]          ADR_O;
  logic                 ACK_I = 1'b0;
  logic                 ERR_I = 1'b0;
  logic                 SINT;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current owner (-1 none), dead edges before next arbitration,
  // per-requester lost-arbitration counts, sticky error flag, unanswered BUS cycles.
  int          mo;
  int          mgap;
  int          mwait;
  int          n_arb;
  int          cnt [NREQ];
  bit          msint;
  // Requester side: beats remaining in the current burst and next beat address.
  int          rem [NREQ];
  logic [29:0] addr [NREQ];
  int          ack_seen [NREQ];

  always #5 CLK_I = ~CLK_I;

  vga_wb_arbiter #(.NREQ(NREQ), .STARVE_LIM(STARVE_LIM)) dut (
    .CLK_I  (CLK_I),
    .nRESET (nRESET),
    .RST_I  (RST_I),
    .ena    (ena),
    .req_i  (req_i),
    .last_i (last_i),
    .adr_i  (adr_i),
    .gnt_o  (gnt_o),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .CYC_O  (CYC_O),
    .STB_O  (STB_O),
    .CAB_O  (CAB_O),
    .WE_O   (WE_O),
    .SEL_O  (SEL_O),
    .ADR_O  (ADR_O),
    .ACK_I  (ACK_I),
    .ERR_I  (ERR_I),
    .SINT   (SINT)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit tmo_now();
    return TMO && (mo >= 0) && (mwait >= 255);
  endfunction

  task automatic model_clear();
    mo = -1; mgap = 0; mwait = 0; msint = 1'b0;
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
  endtask

  task automatic arbitrate(input logic [NREQ-1:0] p_req);
    int w;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && p_req[k] && cnt[k] == STARVE_LIM) w = k;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && p_req[k]) w = k;
    for (int k = 0; k < NREQ; k++) begin
      if (k == w || !p_req[k]) cnt[k] = 0;
      else if (cnt[k] < STARVE_LIM) cnt[k]++;
    end
    mo = w; mwait = 0; n_arb++;
  endtask

  task automatic apply_inputs(input bit ack, input bit err);
    bit   live, fault;
    int   exp_ack, exp_err;
    logic [29:0] exp_adr;
    for (int k = 0; k < NREQ; k++) begin
      req_i[k]          = (rem[k] != 0);
      last_i[k]         = (rem[k] == 1);
      adr_i[k*30 +: 30] = addr[k];
    end
    ACK_I = ack && (mo >= 0);
    ERR_I = err && (mo >= 0);
    #1;
    live    = nRESET && ena && !RST_I;
    fault   = ERR_I || tmo_now();
    exp_ack = (live && mo >= 0 && ACK_I && !fault) ? (1 << mo) : 0;
    exp_err = (live && mo >= 0 && fault) ? (1 << mo) : 0;
    exp_adr = (mo >= 0) ? addr[mo] : 30'd0;
    chk_val("ack_o", 32'(ack_o), 32'(exp_ack));
    chk_val("err_o", 32'(err_o), 32'(exp_err));
    chk_val("ADR_O", 32'(ADR_O), 32'(exp_adr));
    for (int k = 0; k < NREQ; k++) ack_seen[k] += int'(ack_o[k]);
  endtask

  task automatic edge_step();
    logic [NREQ-1:0] p_req, p_last;
    bit   p_ack, p_err, p_tmo, p_live;
    int   exp_gnt;
    p_req  = req_i;
    p_last = last_i;
    p_ack  = ACK_I;
    p_err  = ERR_I;
    p_tmo  = tmo_now();
    p_live = nRESET && ena && !RST_I;
    @(posedge CLK_I);
    #1;
    if (!p_live) model_clear();
    else if (mo >= 0) begin
      if (p_err || p_tmo) begin
        msint = 1'b1; rem[mo] = 0; mo = -1; mgap = 1;
      end else if (p_ack) begin
        rem[mo]--; addr[mo]++; mwait = 0;
        if (p_last[mo]) begin mo = -1; mgap = 1; end
      end else begin
        mwait++;
        if (!p_req[mo]) begin mo = -1; mgap = 1; end
      end
    end else if (mgap > 0) mgap--;
    else if (p_req != '0) arbitrate(p_req);
    exp_gnt = (mo >= 0) ? (1 << mo) : 0;
    chk_val("gnt_o", 32'(gnt_o), 32'(exp_gnt));
    chk_val("CYC_O", 32'(CYC_O), 32'(mo >= 0));
    chk_val("STB_O", 32'(STB_O), 32'(mo >= 0));
    chk_val("CAB_O", 32'(CAB_O), 32'((mo >= 0) ? !p_last[mo] : 1'b0));
    chk_val("SINT",  32'(SINT),  32'(msint));
  endtask

  task automatic cycle(input bit ack, input bit err);
    apply_inputs(ack, err);
    edge_step();
  endtask

  task automatic run_until_owned(input int bound);
    for (int i = 0; i < bound && mo < 0; i++) cycle(1'b0, 1'b0);
    if (mo < 0) chk_val("own_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int bound);
    bool_loop: for (int i = 0; i < bound; i++) begin
      if (mo < 0 && mgap == 0 && rem[0] == 0 && rem[1] == 0 && rem[2] == 0) break;
      cycle(1'b1, 1'b0);
    end
  endtask

  task automatic rand_cycle();
    bit ack, err;
    for (int k = 0; k < NREQ; k++) begin
      if (rem[k] == 0 && mo != k && $urandom_range(0, 3) == 0) begin
        rem[k]  = $urandom_range(1, 4);
        addr[k] = 30'($urandom);
      end
    end
    ack = ($urandom_range(0, 9) < 6);
    err = ($urandom_range(0, 24) == 0);
    // Occasional abandoned burst: owner drops its request with nothing acked.
    if (mo >= 0 && $urandom_range(0, 29) == 0) begin
      rem[mo] = 0; ack = 1'b0; err = 1'b0;
    end
    cycle(ack, err);
  endtask

  initial begin
    int held, base;
    model_clear();
    n_arb = 0;
    for (int k = 0; k < NREQ; k++) begin rem[k] = 0; addr[k] = '0; ack_seen[k] = 0; end

    repeat (2) @(posedge CLK_I);
    #1;
    chk_val("rst_gnt",  32'(gnt_o), 32'd0);
    chk_val("rst_cyc",  32'(CYC_O), 32'd0);
    chk_val("rst_stb",  32'(STB_O), 32'd0);
    chk_val("rst_cab",  32'(CAB_O), 32'd0);
    chk_val("rst_sint", 32'(SINT),  32'd0);
    chk_val("we_o",     32'(WE_O),  32'd0);
    chk_val("sel_o",    32'(SEL_O), 32'hF);
    nRESET = 1'b1;
    ena    = 1'b1;
    cycle(1'b0, 1'b0);

    // Single four-beat burst on requester 0.
    rem[0] = 4; addr[0] = 30'h100; ack_seen[0] = 0;
    cycle(1'b1, 1'b0);
    chk_val("latency_cyc", 32'(CYC_O), 32'd1);
    drain(20);
    chk_val("burst_acks", 32'(ack_seen[0]), 32'd4);

    // Simultaneous requests: 0 first, then 1 ahead of 2.
    rem[0] = 2; rem[1] = 2; rem[2] = 2;
    addr[0] = 30'h200; addr[1] = 30'h300; addr[2] = 30'h400;
    cycle(1'b1, 1'b0);
    chk_val("prio_first", 32'(gnt_o), 32'b001);
    for (int i = 0; i < 30 && mo != 1; i++) cycle(1'b1, 1'b0);
    chk_val("prio_second", 32'(gnt_o), 32'b010);
    drain(40);

    repeat (600) rand_cycle();
    drain(60);

    // Error on the second beat of a requester-1 burst.
    rem[1] = 4; addr[1] = 30'h3000;
    run_until_owned(5);
    cycle(1'b1, 1'b0);
    apply_inputs(1'b1, 1'b1);
    chk_val("err_route", 32'(err_o), 32'b010);
    chk_val("err_noack", 32'(ack_o), 32'd0);
    edge_step();
    chk_val("sint_set", 32'(SINT), 32'd1);
    repeat (5) cycle(1'b0, 1'b0);
    chk_val("sint_sticky", 32'(SINT), 32'd1);

    // ena dropped mid-burst.
    rem[2] = 4; addr[2] = 30'h5000;
    run_until_owned(5);
    cycle(1'b1, 1'b0);
    ena = 1'b0;
    apply_inputs(1'b1, 1'b0);
    chk_val("abort_noack", 32'(ack_o), 32'd0);
    edge_step();
    chk_val("abort_cyc",  32'(CYC_O), 32'd0);
    chk_val("abort_sint", 32'(SINT),  32'd0);
    for (int k = 0; k < NREQ; k++) rem[k] = 0;
    ena = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);

    // Starvation: 0 keeps re-requesting single beats while 2 waits.
    base = n_arb;
    rem[2] = 1; addr[2] = 30'h7000;
    for (int i = 0; i < 300 && (n_arb - base) < 9; i++) begin
      if (rem[0] == 0 && mo != 0) begin rem[0] = 1; addr[0] = 30'($urandom); end
      cycle(1'b1, 1'b0);
    end
    if ((n_arb - base) != 9) chk_val("starve_timeout", 32'd0, 32'd1);
    chk_val("starve_win", 32'(gnt_o), 32'b100);
    rem[0] = 0;
    drain(20);

    // Synchronous RST_I mid-burst.
    rem[1] = 3; addr[1] = 30'h9000;
    run_until_owned(5);
    RST_I = 1'b1;
    apply_inputs(1'b1, 1'b0);
    chk_val("rst_i_noack", 32'(ack_o), 32'd0);
    edge_step();
    chk_val("rst_i_cyc", 32'(CYC_O), 32'd0);
    RST_I = 1'b0;
    for (int k = 0; k < NREQ; k++) rem[k] = 0;
    repeat (2) cycle(1'b0, 1'b0);

    // Asynchronous nRESET mid-burst with SINT already set.
    rem[0] = 3; addr[0] = 30'hA000;
    run_until_owned(5);
    apply_inputs(1'b1, 1'b1);
    edge_step();
    rem[0] = 3;
    run_until_owned(10);
    cycle(1'b1, 1'b0);
    #1 nRESET = 1'b0;
    #1;
    chk_val("async_gnt",  32'(gnt_o), 32'd0);
    chk_val("async_cyc",  32'(CYC_O), 32'd0);
    chk_val("async_sint", 32'(SINT),  32'd0);
    chk_val("async_ack",  32'(ack_o), 32'd0);
    model_clear();
    for (int k = 0; k < NREQ; k++) rem[k] = 0;
    cycle(1'b0, 1'b0);
    nRESET = 1'b1;
    cycle(1'b0, 1'b0);

    // Owner never answered.
    rem[0] = 2; addr[0] = 30'hB000;
    run_until_owned(5);
    held = 0;
    for (int i = 0; i < 1000; i++) begin
      apply_inputs(1'b0, 1'b0);
      if (CYC_O) held++;
      edge_step();
    end
    chk_val("hold_cycles", 32'(held), 32'(EXP_HOLD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
